// File: rtl/histogram_engine.sv
// -----------------------------------------------------------------------------
// histogram_engine
//
// Per-frame pixel histogram. While VSYNC is high every pixel with DataEn=1
// increments its bin in an internal dual-port RAM through a two-stage
// read-modify-write pipeline. When VSYNC falls, the pipeline drains and every
// bin is streamed out over a valid/ready handshake. Each bin is zeroed as it
// is accepted, so the RAM is clean for the next frame.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset (restarts the RAM clear)
//   VSYNC      frame valid, high for the whole active frame
//   DataEn     pixel valid
//   PixelData  pixel value [DATA_WIDTH-1:0]
//   HistValid  readout beat valid
//   HistReady  readout beat accepted
//   HistBin    bin index of the current beat [BIN_WIDTH-1:0]
//   HistCnt    count of the current beat [CNT_WIDTH-1:0]
//   HistLast   high on the beat carrying bin NBINS-1
//   Busy       high while clearing, draining or reading out
//   FrameDrop  sticky; a pixel or frame start arrived while not accumulating
//
// Build option:
//   HISTOGRAM_SATURATE_EN  when defined, bins saturate at all-ones;
//                          otherwise they wrap modulo 2^CNT_WIDTH.
// -----------------------------------------------------------------------------
module histogram_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 18,
  parameter int BIN_SHIFT  = 0,
  localparam int BIN_WIDTH = DATA_WIDTH - BIN_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  VSYNC,
  input  logic                  DataEn,
  input  logic [DATA_WIDTH-1:0] PixelData,
  output logic                  HistValid,
  input  logic                  HistReady,
  output logic [BIN_WIDTH-1:0]  HistBin,
  output logic [CNT_WIDTH-1:0]  HistCnt,
  output logic                  HistLast,
  output logic                  Busy,
  output logic                  FrameDrop
);

  localparam int NBINS = 1 << BIN_WIDTH;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT,
    S_ACC,
    S_DRAIN,
    S_READOUT
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
`ifdef HISTOGRAM_SATURATE_EN
    if (&c) return c;
    return c + CNT_WIDTH'(1);
`else
    return c + CNT_WIDTH'(1);
`endif
  endfunction

  state_t                 state_q, state_d;
  logic                   vsync_q;
  logic                   rise, fall;
  logic [BIN_WIDTH-1:0]   ptr;
  logic [BIN_WIDTH-1:0]   ptr_nxt;
  logic                   ptr_last;
  logic                   drain_q;
  logic                   rd_pend;
  logic                   hist_vld;
  logic [CNT_WIDTH-1:0]   hist_cnt;
  logic                   frame_drop;
  logic                   accept;
  logic                   pix_take;
  logic                   drop_evt;
  logic [BIN_WIDTH-1:0]   pix_bin;

  logic [BIN_WIDTH-1:0]   bin_p0;
  logic                   vld_p0;
  logic [BIN_WIDTH-1:0]   bin_p1;
  logic [CNT_WIDTH-1:0]   cnt_p1;
  logic                   vld_p1;
  logic [CNT_WIDTH-1:0]   base_p0;
  logic [CNT_WIDTH-1:0]   inc_p0;

  logic [CNT_WIDTH-1:0]   mem [NBINS];
  logic [CNT_WIDTH-1:0]   rd_data;
  logic [BIN_WIDTH-1:0]   rd_addr;
  logic                   wr_en;
  logic [BIN_WIDTH-1:0]   wr_addr;
  logic [CNT_WIDTH-1:0]   wr_data;

  assign rise     = VSYNC & ~vsync_q;
  assign fall     = ~VSYNC & vsync_q;
  assign ptr_nxt  = ptr + BIN_WIDTH'(1);
  assign ptr_last = &ptr;
  assign accept   = (state_q == S_READOUT) & hist_vld & HistReady;
  assign pix_take = (state_q == S_ACC) & VSYNC & DataEn;
  assign pix_bin  = BIN_WIDTH'(PixelData >> BIN_SHIFT);
  assign drop_evt = ((state_q == S_CLEAR) | (state_q == S_DRAIN) |
                     (state_q == S_READOUT)) & (rise | DataEn);

  assign HistValid = hist_vld;
  assign HistBin   = ptr;
  assign HistCnt   = hist_cnt;
  assign HistLast  = hist_vld & ptr_last;
  assign Busy      = (state_q == S_CLEAR) | (state_q == S_DRAIN) |
                     (state_q == S_READOUT);
  assign FrameDrop = frame_drop;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (ptr_last) state_d = S_WAIT;
      S_WAIT:    if (rise) state_d = S_ACC;
      S_ACC:     if (fall) state_d = S_DRAIN;
      S_DRAIN:   if (drain_q) state_d = S_READOUT;
      S_READOUT: if (accept && ptr_last) state_d = S_WAIT;
      default:   state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // Control: edge detect, shared bin pointer, drain timer, readout handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      ptr        <= '0;
      drain_q    <= 1'b0;
      rd_pend    <= 1'b0;
      hist_vld   <= 1'b0;
      hist_cnt   <= '0;
      frame_drop <= 1'b0;
    end else begin
      vsync_q <= VSYNC;
      drain_q <= (state_q == S_DRAIN) & ~drain_q;
      if ((state_q == S_WAIT) && rise) frame_drop <= 1'b0;
      else if (drop_evt)               frame_drop <= 1'b1;
      case (state_q)
        S_CLEAR: ptr <= ptr_nxt;
        S_DRAIN: ptr <= '0;
        S_READOUT: begin
          if (!hist_vld) begin
            // rd_pend marks that RAM[ptr] was addressed last cycle and
            // rd_data now holds it
            if (rd_pend) begin
              hist_vld <= 1'b1;
              hist_cnt <= rd_data;
              rd_pend  <= 1'b0;
            end else begin
              rd_pend  <= 1'b1;
            end
          end else if (HistReady) begin
            // next bin is fetched in the same cycle, so valid drops one cycle
            hist_vld <= 1'b0;
            ptr      <= ptr_nxt;
            rd_pend  <= ~ptr_last;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage 0: bin registered, RAM read issued ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= pix_take;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    bin_p0 <= pix_bin;
    bin_p1 <= bin_p0;
    cnt_p1 <= inc_p0;
  end

  // ---- stage 1: read data valid, increment written back ----
  // The write landing on the same edge as this bin's read is not visible in
  // rd_data; take it from the stage-1 copy instead.
  always_comb begin
    base_p0 = rd_data;
    if (vld_p1 && (bin_p1 == bin_p0)) base_p0 = cnt_p1;
    inc_p0 = cnt_inc(base_p0);
  end

  // RAM port muxing
  always_comb begin
    rd_addr = pix_bin;
    if (state_q == S_READOUT) rd_addr = accept ? ptr_nxt : ptr;
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = '0;
    if (state_q == S_CLEAR) begin
      wr_en = 1'b1;
    end else if (accept) begin
      wr_en = 1'b1;
    end else if (vld_p0) begin
      wr_en   = 1'b1;
      wr_addr = bin_p0;
      wr_data = inc_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_histogram_engine.sv
module tb_histogram_engine;

`ifdef HISTOGRAM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int frm;
    int dut;
    int bin;   // -1 means every bin of that DUT
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       VSYNC;
  logic       DataEn;
  logic [7:0] PixelData;
  logic       rdy [3];

  logic        v0, l0, busy0, fd0;
  logic [7:0]  b0;
  logic [17:0] c0;
  logic        v1, l1, busy1, fd1;
  logic [5:0]  b1;
  logic [17:0] c1;
  logic        v2, l2, busy2, fd2;
  logic [7:0]  b2;
  logic [3:0]  c2;

  histogram_engine #(.DATA_WIDTH(8), .CNT_WIDTH(18), .BIN_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .VSYNC(VSYNC), .DataEn(DataEn), .PixelData(PixelData),
    .HistValid(v0), .HistReady(rdy[0]), .HistBin(b0), .HistCnt(c0),
    .HistLast(l0), .Busy(busy0), .FrameDrop(fd0));

  histogram_engine #(.DATA_WIDTH(8), .CNT_WIDTH(18), .BIN_SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .VSYNC(VSYNC), .DataEn(DataEn), .PixelData(PixelData),
    .HistValid(v1), .HistReady(rdy[1]), .HistBin(b1), .HistCnt(c1),
    .HistLast(l1), .Busy(busy1), .FrameDrop(fd1));

  histogram_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4), .BIN_SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .VSYNC(VSYNC), .DataEn(DataEn), .PixelData(PixelData),
    .HistValid(v2), .HistReady(rdy[2]), .HistBin(b2), .HistCnt(c2),
    .HistLast(l2), .Busy(busy2), .FrameDrop(fd2));

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   nb [3] = '{256, 64, 256};
  int   n [3];
  int   got [3][256];
  int   hv [3], hb [3], hc [3], hl [3], hbusy [3], hfd [3];
  exp_t tbl [$];
  int   px [$];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic sample();
    hv[0] = int'(v0); hb[0] = int'(b0); hc[0] = int'(c0); hl[0] = int'(l0);
    hbusy[0] = int'(busy0); hfd[0] = int'(fd0);
    hv[1] = int'(v1); hb[1] = int'(b1); hc[1] = int'(c1); hl[1] = int'(l1);
    hbusy[1] = int'(busy1); hfd[1] = int'(fd1);
    hv[2] = int'(v2); hb[2] = int'(b2); hc[2] = int'(c2); hl[2] = int'(l2);
    hbusy[2] = int'(busy2); hfd[2] = int'(fd2);
  endtask

  function automatic int exp_cnt(input int frm, input int d, input int b);
    int r = 0;
    foreach (tbl[i])
      if (tbl[i].frm == frm && tbl[i].dut == d && (tbl[i].bin == b || tbl[i].bin == -1))
        r = tbl[i].cnt;
    return r;
  endfunction

  // Counts Busy-high cycles starting at the negedge where rst was released.
  task automatic measure_busy();
    int cnt [3] = '{0, 0, 0};
    for (int c = 0; c < 400; c++) begin
      sample();
      for (int d = 0; d < 3; d++) cnt[d] += hbusy[d];
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) chk($sformatf("clear_cycles d%0d", d), cnt[d], nb[d]);
  endtask

  task automatic run_frame();
    @(negedge clk);
    VSYNC = 1'b1;
    @(negedge clk);
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("drop_clr_acc d%0d", d), hfd[d], 0);
      chk($sformatf("busy_acc d%0d", d), hbusy[d], 0);
    end
    foreach (px[i]) begin
      DataEn = 1'b1;
      PixelData = 8'(px[i]);
      @(negedge clk);
    end
    DataEn = 1'b0;
    @(negedge clk);
    VSYNC = 1'b0;
  endtask

  task automatic readout(input int pulse_at, input int abort_at);
    int  stall [3];
    int  pb [3];
    int  pc [3];
    bit  done = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n[d] = 0; stall[d] = 0; pb[d] = 0; pc[d] = 0;
      for (int b = 0; b < 256; b++) got[d][b] = -1;
    end
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == abort_at) begin
        done = 1'b1;
      end else begin
        if (pulse_at >= 0) begin
          if (cyc == pulse_at) begin VSYNC = 1'b1; DataEn = 1'b1; PixelData = 8'd1; end
          if (cyc == pulse_at + 1) DataEn = 1'b0;
          if (cyc == pulse_at + 2) VSYNC = 1'b0;
        end
        sample();
        if (pulse_at >= 0 && cyc == pulse_at + 4)
          for (int d = 0; d < 3; d++) chk($sformatf("drop_set d%0d", d), hfd[d], 1);
        for (int d = 0; d < 3; d++) begin
          if (stall[d] != 0) begin
            chk($sformatf("stall_valid d%0d", d), hv[d], 1);
            chk($sformatf("stall_bin d%0d", d), hb[d], pb[d]);
            chk($sformatf("stall_cnt d%0d", d), hc[d], pc[d]);
          end
          rdy[d] = (d == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          stall[d] = 0;
          if (hv[d] != 0) begin
            if (rdy[d]) begin
              chk($sformatf("beat_bin d%0d", d), hb[d], n[d]);
              chk($sformatf("beat_last d%0d b%0d", d, hb[d]), hl[d], (n[d] == nb[d] - 1) ? 1 : 0);
              got[d][hb[d]] = hc[d];
              n[d]++;
            end else begin
              stall[d] = 1; pb[d] = hb[d]; pc[d] = hc[d];
            end
          end
        end
        if (n[0] == nb[0] && n[1] == nb[1] && n[2] == nb[2]) done = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rdy[d] = 1'b1;
  endtask

  task automatic check_frame(input int frm);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("beats f%0d d%0d", frm, d), n[d], nb[d]);
      for (int b = 0; b < nb[d]; b++)
        chk($sformatf("cnt f%0d d%0d b%0d", frm, d, b), got[d][b], exp_cnt(frm, d, b));
    end
    sample();
    for (int d = 0; d < 3; d++) chk($sformatf("idle f%0d d%0d", frm, d), hbusy[d], 0);
  endtask

  initial begin
    // expected non-zero bins per frame: {frame, dut, bin, count}
    tbl.push_back(exp_t'{1, 0, 7, 1000});
    tbl.push_back(exp_t'{1, 1, 1, 1000});
    tbl.push_back(exp_t'{1, 2, 7, SAT ? 15 : 8});
    tbl.push_back(exp_t'{2, 0, 3, 32});
    tbl.push_back(exp_t'{2, 0, 5, 32});
    tbl.push_back(exp_t'{2, 0, 9, 3});
    tbl.push_back(exp_t'{2, 0, 4, 1});
    tbl.push_back(exp_t'{2, 1, 0, 32});
    tbl.push_back(exp_t'{2, 1, 1, 33});
    tbl.push_back(exp_t'{2, 1, 2, 3});
    tbl.push_back(exp_t'{2, 2, 3, SAT ? 15 : 0});
    tbl.push_back(exp_t'{2, 2, 5, SAT ? 15 : 0});
    tbl.push_back(exp_t'{2, 2, 9, 3});
    tbl.push_back(exp_t'{2, 2, 4, 1});
    tbl.push_back(exp_t'{3, 0, -1, 1});
    tbl.push_back(exp_t'{3, 1, -1, 4});
    tbl.push_back(exp_t'{3, 2, -1, 1});
    for (int f = 4; f <= 5; f++) begin
      tbl.push_back(exp_t'{f, 0, 1, 20});
      tbl.push_back(exp_t'{f, 1, 0, 20});
      tbl.push_back(exp_t'{f, 2, 1, SAT ? 15 : 4});
    end
    tbl.push_back(exp_t'{7, 0, 200, 5});
    tbl.push_back(exp_t'{7, 1, 50, 5});
    tbl.push_back(exp_t'{7, 2, 200, 5});

    rst = 1'b1; VSYNC = 1'b0; DataEn = 1'b0; PixelData = 8'd0;
    for (int d = 0; d < 3; d++) rdy[d] = 1'b1;

    @(negedge clk);
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid d%0d", d), hv[d], 0);
      chk($sformatf("rst_bin d%0d", d), hb[d], 0);
      chk($sformatf("rst_cnt d%0d", d), hc[d], 0);
      chk($sformatf("rst_last d%0d", d), hl[d], 0);
      chk($sformatf("rst_busy d%0d", d), hbusy[d], 1);
      chk($sformatf("rst_drop d%0d", d), hfd[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    measure_busy();

    // frame 0: empty
    px.delete();
    run_frame(); readout(-1, -1); check_frame(0);

    // frame 1: 1000 back-to-back pixels of 7
    px.delete();
    for (int i = 0; i < 1000; i++) px.push_back(7);
    run_frame(); readout(-1, -1); check_frame(1);

    // frame 2: 3,5 alternating then 9,9,4,9
    px.delete();
    for (int i = 0; i < 32; i++) begin px.push_back(3); px.push_back(5); end
    px.push_back(9); px.push_back(9); px.push_back(4); px.push_back(9);
    run_frame(); readout(-1, -1); check_frame(2);

    // frame 3: every pixel value once
    px.delete();
    for (int i = 0; i < 256; i++) px.push_back(i);
    run_frame(); readout(-1, -1); check_frame(3);

    // frames 4 and 5: identical, drop pulses during the first readout
    px.delete();
    for (int i = 0; i < 20; i++) px.push_back(1);
    run_frame(); readout(10, -1); check_frame(4);
    sample();
    for (int d = 0; d < 3; d++) chk($sformatf("drop_sticky d%0d", d), hfd[d], 1);
    run_frame(); readout(-1, -1); check_frame(5);

    // frame 6: aborted by reset mid-readout, leaves dirty bins behind
    px.delete();
    for (int i = 0; i < 20; i++) px.push_back(1);
    for (int i = 0; i < 3; i++) px.push_back(250);
    run_frame(); readout(10, 30);
    rst = 1'b1;
    @(negedge clk);
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst2_valid d%0d", d), hv[d], 0);
      chk($sformatf("rst2_bin d%0d", d), hb[d], 0);
      chk($sformatf("rst2_cnt d%0d", d), hc[d], 0);
      chk($sformatf("rst2_last d%0d", d), hl[d], 0);
      chk($sformatf("rst2_busy d%0d", d), hbusy[d], 1);
      chk($sformatf("rst2_drop d%0d", d), hfd[d], 0);
    end
    rst = 1'b0;
    measure_busy();

    // frame 7: fresh frame after the abort
    px.delete();
    for (int i = 0; i < 5; i++) px.push_back(200);
    run_frame(); readout(-1, -1); check_frame(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histogram_engine.md
Name: histogram_engine

Overview:
- Parametrised per-frame pixel histogram engine for the video pipeline, placed after the sensor/DE stage.
- Accumulates bin counts in an internal dual-port RAM while VSYNC is high.
- At frame end it drains the pipeline and streams every bin out over a valid/ready handshake.
- Each bin is zeroed as it is read, so the RAM is clean for the next frame.
- Generalises the first-generation counter with bin coarsening, exact counts on repeated pixels, readout, clear and drop reporting.

Parameters:
- DATA_WIDTH, 8: pixel width.
- CNT_WIDTH, 18: per-bin counter width.
- BIN_SHIFT, 0: bin index = PixelData >> BIN_SHIFT; BIN_WIDTH = DATA_WIDTH - BIN_SHIFT; NBINS = 2^BIN_WIDTH. Legal range 0..DATA_WIDTH-1.

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- VSYNC  in  1  frame-valid; high for the whole active frame
- DataEn  in  1  pixel valid
- PixelData  in  DATA_WIDTH  pixel value
- HistValid  out  1  readout beat valid
- HistReady  in  1  readout beat accepted
- HistBin  out  BIN_WIDTH  bin index of the current beat
- HistCnt  out  CNT_WIDTH  count of the current beat
- HistLast  out  1  high on the beat with HistBin = NBINS-1
- Busy  out  1  high in CLEAR, DRAIN and READOUT
- FrameDrop  out  1  sticky: a valid pixel arrived while not in ACC

Behaviour:
- Reset values: HistValid=0, HistBin=0, HistCnt=0, HistLast=0, Busy=1 (enters CLEAR), FrameDrop=0. All pipeline valids are cleared.
- States: CLEAR, WAIT, ACC, DRAIN, READOUT.
- CLEAR:
  - Writes 0 to bins 0..NBINS-1, one per cycle (NBINS cycles), then goes to WAIT.
  - Entered only from reset. rst mid-operation from any state aborts it and restarts CLEAR.
- WAIT:
  - Waits for a VSYNC rising edge (VSYNC registered once; edge = current & ~previous), then goes to ACC.
  - Busy=0 in WAIT and ACC.
- ACC:
  - Each cycle with DataEn=1 and VSYNC=1 counts one pixel.
  - Stage 0 registers the bin index and enable, and issues the RAM read.
  - Stage 1 (read data valid, 1-cycle synchronous RAM) writes count+1 to the same bin.
  - Results must be exact for any sequence, including runs of identical bins on consecutive cycles and A,B,A patterns. Implement this with write-to-read forwarding on address match; never rely on RAM collision semantics.
  - On the VSYNC falling edge go to DRAIN. DataEn is ignored once VSYNC is low.
- DRAIN: 2 cycles, so all in-flight increments are committed, then READOUT with bin pointer = 0.
- READOUT:
  - HistValid=1, HistBin=pointer, HistCnt=RAM[pointer]. Output is registered and holds stable while HistValid=1 and HistReady=0.
  - On HistValid & HistReady: write 0 to RAM[pointer], advance the pointer, and present the next bin on the following cycle (HistValid may drop for at most 1 cycle between beats).
  - After the beat with HistLast=1 is accepted, go to WAIT with HistValid=0.
- Drops: a VSYNC rising edge or DataEn=1 during CLEAR, DRAIN or READOUT is not counted and sets FrameDrop. FrameDrop clears only on entry to ACC.
- Arithmetic: increments are CNT_WIDTH wide; overflow handling is selected by the Optional Feature below.
- A frame with zero pixels still produces a full NBINS-beat readout of zeros.

Optional Feature:
- Macro HISTOGRAM_SATURATE_EN.
- Defined: a bin holding 2^CNT_WIDTH-1 stays at 2^CNT_WIDTH-1 on further increments (forwarded values saturate identically).
- Undefined: the counter wraps modulo 2^CNT_WIDTH (all-ones + 1 = 0).

Test Plan:
- After reset: Busy=1 for NBINS=256 cycles, then 0; a readout of an empty frame gives 256 beats, all HistCnt=0, HistLast only on HistBin=255.
- Frame of 1000 consecutive pixels of value 7 with DataEn held high: HistCnt=1000 at bin 7, 0 elsewhere (checks forwarding on back-to-back hits).
- Alternating pattern 3,5,3,5,… for 64 pixels plus the sequence 9,9,4,9: bins 3=32, 5=32, 9=3, 4=1.
- BIN_SHIFT=2, pixels 0..255 once each: 64 beats, each HistCnt=4. HistReady toggled randomly: no beat lost or duplicated, outputs stable while stalled.
- CNT_WIDTH=4, 20 pixels of value 1: with HISTOGRAM_SATURATE_EN, bin 1=15; without it, bin 1=4. A second identical frame gives the same result (clear-on-read verified).
- VSYNC rising and DataEn pulses during READOUT: those pixels are not counted and FrameDrop=1. FrameDrop returns to 0 on the next ACC entry. rst asserted mid-READOUT gives all outputs at reset values and a fresh CLEAR.
